adder_arbiter: RTL
==================

# adder_arbiter

Shares one multi-precision adder/subtractor (start/subtract/shift/done handshake, WIDTH-bit operands, WIDTH+1-bit result) between two requesters, e.g. a Montgomery multiplier loop and a final conditional-subtract/compare stage.

The arbiter works round-robin. It latches the winner's operands, sequences the adder's start, optional shift and result capture, and returns the result on the requester's response port.

A watchdog reports an error if the adder never signals done.

## Interface
- WIDTH, 514, operand width; the result is WIDTH+1 bits.
- TIMEOUT, 1023, the maximum number of cycles spent in WAIT before an error response.

- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending; held until accepted.
- req0_ready / req1_ready  out  1  accept strobe; the request transfers when valid && ready.
- req0_subtract / req1_subtract  in  1  0 = a+b, 1 = a-b (two's complement).
- req0_shift / req1_shift  in  1  shift the adder result right by 1 before returning it.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse.
- rsp0_result / rsp1_result  out  WIDTH+1  result, held until the next response on the same port.
- rsp0_err / rsp1_err  out  1  timeout flag, qualified by rspX_valid and held like the result.
- add_start  out  1  one-cycle start pulse to the adder.
- add_subtract  out  1  subtract select; stable from START until return to IDLE.
- add_shift  out  1  one-cycle shift pulse to the adder.
- add_in_a, add_in_b  out  WIDTH  latched operands; stable from START until return to IDLE.
- add_result  in  WIDTH+1  adder result.
- add_done  in  1  adder result valid.

## Operation
**Reset values.** All outputs are 0, state is IDLE, last_grant = 1 (so req0 wins first), and the timeout counter is 0.

**States and transitions.**
- IDLE:
  - sel = the only valid requester; if both are valid, sel = the one that is not last_grant.
  - reqX_ready = (state==IDLE) && valid && sel==X. This is combinational, and at most one ready is high at a time.
  - On accept, latch a, b, subtract, shift and owner, set last_grant = owner, and go to START.
- START: add_start=1 for exactly one cycle, then go to WAIT.
  - The adder must clear any held done on start.
  - add_done is ignored in START.
- WAIT: the timeout counter increments every cycle.
  - add_done=1 and shift=0: capture add_result, go to RESP.
  - add_done=1 and shift=1: go to SHIFT.
  - Counter == TIMEOUT without done: set result = 0, err = 1, go to RESP.
- SHIFT: add_shift=1 for one cycle, then go to SETTLE.
- SETTLE: capture add_result (the shifted value), go to RESP.
- RESP: rsp<owner>_valid=1 with the captured result and err (err=0 on a normal completion) for one cycle. Clear the counter and go to IDLE.

**Boundary conditions.**
- Arithmetic is done entirely in the adder. The arbiter neither modifies nor truncates the WIDTH+1-bit result.
  - Subtract underflow wraps modulo 2^(WIDTH+1), e.g. 0-1 = all ones.
- A request arriving while the block is busy sees ready=0 and must hold valid. Dropping valid before acceptance is legal and nothing is queued.
- Both requesters holding valid continuously are served alternately: 0, 1, 0, 1.
- While the arbiter is not in IDLE, request inputs may change freely; only the latched copies drive the adder.
- Reset asserted in any state:
  - All outputs go to 0 immediately.
  - The in-flight request is discarded with no response.
  - The state returns to IDLE and last_grant returns to 1.
  - The adder shares resetn.
- After a timeout the adder state is undefined. The system must reset before the next request; the arbiter itself keeps operating.

## Timing
- Accept edge = cycle 0, START = cycle 1, and add_done first seen in WAIT at cycle 1+L, where L ≥ 1 is the adder latency.
- Without shift: RESP at cycle 2+L, so request-to-response = L+2 cycles.
- With shift: SHIFT at 2+L, SETTLE at 3+L, RESP at 4+L.
- A timeout response arrives TIMEOUT+1 cycles after entering WAIT.
- The earliest next accept is the cycle after RESP (IDLE). Back-to-back throughput is one operation per L+3 cycles.
- All state, add_* controls and rsp_* outputs are registered except reqX_ready.

## Test plan
- Add 1+1 on req0 with an adder model of L=3: req0_ready pulses once, add_start pulses at cycle 1, rsp0_valid pulses at cycle 5 with rsp0_result=2 and rsp0_err=0, and rsp1_valid stays 0.
- Subtract on req1, 1-1 and then 0-1: results are 0 and 515'h7ff…f (all ones), and add_subtract=1 is held through WAIT.
- Add-with-shift on req0, 3+3 with shift=1: add_shift pulses exactly once after add_done, rsp0_result=3, and the response arrives at L+4.
- Both requesters valid from reset exit, each reissuing immediately: grant order is 0, 1, 0, 1, and each rsp pulse returns its own operands' sum.
- Adder model never asserts done with TIMEOUT=15: rsp valid arrives 16 cycles after entering WAIT with result=0 and err=1, then IDLE accepts the next request.
- Reset asserted in WAIT: add_start, add_shift, ready and all rsp outputs read 0 with no clock edge, no response is issued, and after release req0 wins the first grant.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one multi-precision adder/subtractor between two requesters
module adder_arbiter #(
    parameter int WIDTH   = 514,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_subtract,
    input  logic             req0_shift,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_subtract,
    input  logic             req1_shift,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic [WIDTH:0]   rsp0_result,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    output logic [WIDTH:0]   rsp1_result,
    output logic             rsp1_err,
    output logic             add_start,
    output logic             add_subtract,
    output logic             add_shift,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, START, WAIT, SHIFT, SETTLE, RESP} state_t;
    state_t         state;
    logic           last_grant;
    logic           owner;
    logic           shift_q;
    logic [CW-1:0]  cnt;
    logic           idle;
    logic           grant;
    logic           timeout;
    logic           capture;
    logic [WIDTH:0] cap_result;
    // grant selection and result capture; ready is masked by reset so it drops without a clock edge
    always_comb begin
        idle       = resetn && state == IDLE;
        req0_ready = idle && req0_valid && (!req1_valid || last_grant);
        req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
        grant      = req1_ready;
        timeout    = state == WAIT && !add_done && cnt == CW'(TIMEOUT);
        capture    = (state == WAIT && add_done && !shift_q) || timeout || state == SETTLE;
        cap_result = timeout ? '0 : add_result;
    end
    // sequencer: latch the winner, pulse start/shift, watch for timeout and emit the response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            shift_q      <= 1'b0;
            cnt          <= '0;
            add_start    <= 1'b0;
            add_shift    <= 1'b0;
            add_subtract <= 1'b0;
            add_in_a     <= '0;
            add_in_b     <= '0;
            rsp0_valid   <= 1'b0;
            rsp0_result  <= '0;
            rsp0_err     <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_result  <= '0;
            rsp1_err     <= 1'b0;
        end else begin
            add_start  <= 1'b0;
            add_shift  <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    state        <= START;
                    add_start    <= 1'b1;
                    owner        <= grant;
                    last_grant   <= grant;
                    shift_q      <= grant ? req1_shift : req0_shift;
                    add_subtract <= grant ? req1_subtract : req0_subtract;
                    add_in_a     <= grant ? req1_a : req0_a;
                    add_in_b     <= grant ? req1_b : req0_b;
                end
                START: state <= WAIT;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (add_done && shift_q) begin
                        state     <= SHIFT;
                        add_shift <= 1'b1;
                    end else if (capture) begin
                        state <= RESP;
                    end
                end
                SHIFT:  state <= SETTLE;
                SETTLE: state <= RESP;
                RESP: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
            if (capture && !owner) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= cap_result;
                rsp0_err    <= timeout;
            end
            if (capture && owner) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= cap_result;
                rsp1_err    <= timeout;
            end
        end
    end
endmodule
